// File: rtl/mac_feed_ctrl.sv
// Initiator side of the pipelined MAC interface: feeds NUM_TAPS operand pairs per window and returns the narrowed result.
// Optional macro CONV_SAT_EN: saturating narrow with sat_flag; when undefined the result wraps and sat_flag is 0.
module mac_feed_ctrl #(
  parameter int INW      = 24,
  parameter int OUTW     = 48,
  parameter int RESW     = 24,
  parameter int NUM_TAPS = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic signed [INW-1:0]  in_a,
  input  logic signed [INW-1:0]  in_b,
  input  logic signed [INW-1:0]  in_bias,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic signed [RESW-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sat_flag,
  output logic signed [INW-1:0]  mac_input0,
  output logic signed [INW-1:0]  mac_input1,
  output logic signed [INW-1:0]  mac_init_value,
  output logic                   mac_init_acc,
  output logic                   mac_input_valid,
  input  logic signed [OUTW-1:0] mac_out
);

  localparam int CNTW = $clog2(NUM_TAPS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] tap_cnt;
  logic [1:0]      drain_cnt;
  logic            in_fire, out_fire, last_tap, capture;
  logic [RESW-1:0] narrow_data;
  logic            narrow_sat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_fire) state_nxt = (NUM_TAPS == 1) ? DRAIN : LOAD;
      LOAD:    if (in_fire && last_tap) state_nxt = DRAIN;
      DRAIN:   if (capture) state_nxt = OUT;
      OUT:     if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = reset_n && ((state == IDLE) || (state == LOAD));
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    last_tap = (tap_cnt == CNTW'(NUM_TAPS - 1));
    // DRAIN spans the multiply and accumulate stages; the third edge after the last pair sees the final sum
    capture  = (state == DRAIN) && (drain_cnt == 2'd2);
  end

`ifdef CONV_SAT_EN
  localparam logic signed [OUTW-1:0] RES_MAX = {{(OUTW-RESW+1){1'b0}}, {(RESW-1){1'b1}}};
  localparam logic signed [OUTW-1:0] RES_MIN = {{(OUTW-RESW+1){1'b1}}, {(RESW-1){1'b0}}};

  always_comb begin
    narrow_data = mac_out[RESW-1:0];
    narrow_sat  = 1'b0;
    if (mac_out > RES_MAX) begin
      narrow_data = RES_MAX[RESW-1:0];
      narrow_sat  = 1'b1;
    end else if (mac_out < RES_MIN) begin
      narrow_data = RES_MIN[RESW-1:0];
      narrow_sat  = 1'b1;
    end
  end
`else
  always_comb begin
    narrow_data = mac_out[RESW-1:0];
    narrow_sat  = 1'b0;
  end

  if (OUTW > RESW) begin : g_unused_hi
    logic unused_mac_hi;
    assign unused_mac_hi = ^mac_out[OUTW-1:RESW];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap_cnt         <= '0;
      drain_cnt       <= '0;
      mac_input0      <= '0;
      mac_input1      <= '0;
      mac_init_value  <= '0;
      mac_init_acc    <= 1'b0;
      mac_input_valid <= 1'b0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      sat_flag        <= 1'b0;
    end else begin
      mac_init_acc    <= 1'b0;
      mac_input_valid <= 1'b0;
      if (in_fire) begin
        mac_input0      <= in_a;
        mac_input1      <= in_b;
        mac_input_valid <= 1'b1;
        if (state == IDLE) begin
          mac_init_acc   <= 1'b1;
          mac_init_value <= in_bias;
          tap_cnt        <= CNTW'(1);
        end else begin
          tap_cnt <= tap_cnt + CNTW'(1);
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (capture) begin
        out_data  <= narrow_data;
        out_valid <= 1'b1;
        sat_flag  <= narrow_sat;
        tap_cnt   <= '0;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        sat_flag  <= 1'b0;
      end
    end
  end

endmodule
